// File: rtl/midori64_round_ctrl.sv
// Control sequencer for the masked Midori64 datapath: whitening, NR full rounds and a
// final round, each round spanning SBOX_STAGES cycles of the TI S-box pipeline.
module midori64_round_ctrl #(
  parameter int SBOX_STAGES = 2,
  parameter int NR          = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       load_o,
  output logic       state_en_o,
  output logic       sbox_en_o,
  output logic [1:0] key_sel_o,
  output logic       last_o,
  output logic [3:0] rc_idx_o,
  output logic       out_valid_o,
  output logic [2:0] dbg_state_o
);

  localparam int SW = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(SBOX_STAGES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(NR - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WHITEN = 3'd1,
    S_ROUND  = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] round, round_n;
  logic [SW-1:0] stage, stage_n;
  logic          last_stage;

  logic       busy_d, load_d, state_en_d, sbox_d, last_d, out_valid_d;
  logic [1:0] key_sel_d;
  logic [3:0] rc_d;

  assign last_stage  = (stage == STAGE_LAST);
  assign dbg_state_o = state;

  // Output handshake: the ciphertext shares transfer on an edge where out_valid_o and
  // out_ready_i are both high; out_valid_o stays high until that edge.
  always_comb begin
    state_n = state;
    round_n = round;
    stage_n = stage;
    case (state)
      S_IDLE: begin
        round_n = '0;
        stage_n = '0;
        if (start_i) state_n = S_WHITEN;
      end
      S_WHITEN: begin
        round_n = '0;
        stage_n = '0;
        state_n = S_ROUND;
      end
      S_ROUND: begin
        if (last_stage) begin
          stage_n = '0;
          if (round == ROUND_LAST) state_n = S_FINAL;
          else                     round_n = round + RW'(1);
        end else begin
          stage_n = stage + SW'(1);
        end
      end
      S_FINAL: begin
        if (last_stage) begin
          stage_n = '0;
          state_n = S_DONE;
        end else begin
          stage_n = stage + SW'(1);
        end
      end
      S_DONE: begin
        round_n = '0;
        if (out_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies match the state
  // they belong to in the same cycle.
  always_comb begin
    busy_d      = (state_n != S_IDLE);
    load_d      = (state_n == S_WHITEN);
    sbox_d      = (state_n == S_ROUND) || (state_n == S_FINAL);
    state_en_d  = load_d || (sbox_d && (stage_n == STAGE_LAST));
    last_d      = (state_n == S_FINAL);
    out_valid_d = (state_n == S_DONE);
    key_sel_d   = 2'd0;
    rc_d        = 4'd0;
    if (state_n == S_ROUND) begin
      key_sel_d = round_n[0] ? 2'd2 : 2'd1;
      rc_d      = 4'(round_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      round       <= '0;
      stage       <= '0;
      busy_o      <= 1'b0;
      load_o      <= 1'b0;
      state_en_o  <= 1'b0;
      sbox_en_o   <= 1'b0;
      key_sel_o   <= 2'd0;
      last_o      <= 1'b0;
      rc_idx_o    <= 4'd0;
      out_valid_o <= 1'b0;
    end else begin
      state       <= state_n;
      round       <= round_n;
      stage       <= stage_n;
      busy_o      <= busy_d;
      load_o      <= load_d;
      state_en_o  <= state_en_d;
      sbox_en_o   <= sbox_d;
      key_sel_o   <= key_sel_d;
      last_o      <= last_d;
      rc_idx_o    <= rc_d;
      out_valid_o <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_midori64_round_ctrl.sv
// Bench for midori64_round_ctrl: three builds (SBOX_STAGES = 2, 1, 3) share the stimulus
// and are checked every cycle against a schedule model indexed by cycles since start.
module tb_midori64_round_ctrl;

  localparam int NR = 15;

  typedef struct packed {
    logic       busy;
    logic       load;
    logic       state_en;
    logic       sbox_en;
    logic [1:0] key_sel;
    logic       last;
    logic [3:0] rc;
    logic       out_valid;
  } outs_t;

  logic clk, rst_n, start, out_ready;
  logic       busy[3], load[3], state_en[3], sbox[3], last[3], out_valid[3];
  logic [1:0] key_sel[3];
  logic [3:0] rc[3];
  logic [2:0] dbg[3];
  outs_t      got[3];

  int checks = 0;
  int errors = 0;

  function automatic int s_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 3;
  endfunction

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    midori64_round_ctrl #(.SBOX_STAGES(S), .NR(NR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .out_ready_i(out_ready),
      .busy_o     (busy[g]),
      .load_o     (load[g]),
      .state_en_o (state_en[g]),
      .sbox_en_o  (sbox[g]),
      .key_sel_o  (key_sel[g]),
      .last_o     (last[g]),
      .rc_idx_o   (rc[g]),
      .out_valid_o(out_valid[g]),
      .dbg_state_o(dbg[g])
    );
    assign got[g] = {busy[g], load[g], state_en[g], sbox[g], key_sel[g], last[g], rc[g], out_valid[g]};
  end

  // ---------------- model ----------------
  // t = 0 idle; t = 1 whitening; then NR*s round cycles, s final cycles, then done.
  function automatic outs_t model(input int t, input int s);
    outs_t o;
    int fin_t, done_t, rnd, stg;
    o      = '0;
    fin_t  = 2 + NR * s;
    done_t = fin_t + s;
    rnd    = (t - 2) / s;
    stg    = (t - 2) % s;
    if (t != 0) o.busy = 1'b1;
    if (t == 1) begin
      o.load     = 1'b1;
      o.state_en = 1'b1;
    end
    if (t >= 2 && t < done_t) begin
      o.sbox_en = 1'b1;
      if (stg == s - 1) o.state_en = 1'b1;
    end
    if (t >= 2 && t < fin_t) begin
      o.key_sel = (rnd % 2 == 0) ? 2'd1 : 2'd2;
      o.rc      = 4'(rnd);
    end
    if (t >= fin_t && t < done_t) o.last = 1'b1;
    if (t == done_t) o.out_valid = 1'b1;
    return o;
  endfunction

  int m_t[3] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_t[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_t[i] == 0)                          m_t[i] <= start ? 1 : 0;
        else if (m_t[i] < 2 + (NR + 1) * s_of(i)) m_t[i] <= m_t[i] + 1;
        else if (out_ready)                       m_t[i] <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int got_v, input int exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got_v, exp_v);
    end
  endtask

  task automatic chk_o(input string name, input outs_t got_v, input outs_t exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, got_v, exp_v, m_t[0]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      chk_o($sformatf("cycle_inst%0d", i), got[i], model(m_t[i], s_of(i)));
  end

  logic [3:0] exp_q[$];
  logic [1:0] exp_key[$];
  logic [3:0] got_rc[$];
  logic [1:0] got_key[$];
  int v_t[$];
  int lat[3];
  int se_cnt, sb_cnt, load_cnt, val_cnt;

  // ---------------- driver ----------------
  task automatic run_enc(input int limit, input int inject_at, input int abort_at, input bit hold);
    logic prev_v;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    se_cnt = 0; sb_cnt = 0; load_cnt = 0; val_cnt = 0; prev_v = 1'b0;
    v_t.delete(); got_rc.delete(); got_key.delete();
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (!hold && k == 0) start = 1'b0;
      for (int i = 0; i < 3; i++) if (out_valid[i] && lat[i] < 0) lat[i] = k;
      if (busy[0] && !out_valid[0]) got_key.push_back(key_sel[0]);
      if (sbox[0] && !last[0]) got_rc.push_back(rc[0]);
      se_cnt   += int'(state_en[0]);
      sb_cnt   += int'(sbox[0]);
      load_cnt += int'(load[0]);
      val_cnt  += int'(out_valid[0]);
      if (out_valid[0] && !prev_v) v_t.push_back(k);
      prev_v = out_valid[0];
      if (inject_at >= 0 && k == inject_at) start = 1'b1;
      if (inject_at >= 0 && k == inject_at + 1) start = 1'b0;
      if (k == abort_at) begin
        chk("abort_rc_idx", int'(rc[0]), 7);
        chk("abort_stage_last", int'(state_en[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk_o($sformatf("async_reset_inst%0d", i), got[i], '0);
        break;
      end
    end
  endtask

  task automatic check_seqs();
    int bad;
    chk("rc_seq_len", got_rc.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_rc.size() && i < exp_q.size(); i++) if (got_rc[i] !== exp_q[i]) bad++;
    chk("rc_seq_mismatches", bad, 0);
    chk("key_seq_len", got_key.size(), exp_key.size());
    bad = 0;
    for (int i = 0; i < got_key.size() && i < exp_key.size(); i++) if (got_key[i] !== exp_key[i]) bad++;
    chk("key_seq_mismatches", bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int r = 0; r < NR; r++) begin
      exp_q.push_back(4'(r));
      exp_q.push_back(4'(r));
    end
    exp_key.push_back(2'd0);
    for (int r = 0; r < NR; r++) begin
      exp_key.push_back((r % 2 == 0) ? 2'd1 : 2'd2);
      exp_key.push_back((r % 2 == 0) ? 2'd1 : 2'd2);
    end
    exp_key.push_back(2'd0);
    exp_key.push_back(2'd0);

    start = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_o($sformatf("reset_inst%0d", i), got[i], '0);
    #19 rst_n = 1'b1;

    // single encryption, then backpressure for the remainder of the window
    run_enc(60, -1, -1, 1'b0);
    chk("latency_s2", lat[0], 33);
    chk("latency_s1", lat[1], 17);
    chk("latency_s3", lat[2], 49);
    chk("state_en_pulses", se_cnt, 17);
    chk("sbox_en_cycles", sb_cnt, 32);
    chk("load_pulses", load_cnt, 1);
    chk("valid_held_cycles", val_cnt, 27);
    check_seqs();
    chk("bp_valid", int'(out_valid[0]), 1);
    chk("bp_busy", int'(busy[0]), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk($sformatf("ready_exit_inst%0d", i), int'(busy[i]), 0);

    // start pulse during round 5 is ignored
    run_enc(60, 11, -1, 1'b0);
    chk("ignored_start_latency", lat[0], 33);
    chk("ignored_start_valid_rises", v_t.size(), 1);
    chk("ready_high_valid_cycles", val_cnt, 1);
    chk("ignored_start_load", load_cnt, 1);

    // reset during round 7 stage 1, then a full run
    run_enc(60, -1, 16, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_enc(60, -1, -1, 1'b0);
    chk("post_abort_latency_s2", lat[0], 33);
    chk("post_abort_latency_s1", lat[1], 17);
    chk("post_abort_latency_s3", lat[2], 49);
    chk("post_abort_state_en", se_cnt, 17);
    check_seqs();

    // back-to-back: start held, ready held
    run_enc(105, -1, -1, 1'b1);
    start = 1'b0;
    chk("b2b_valid_rises", v_t.size(), 3);
    if (v_t.size() >= 3) begin
      chk("b2b_period_1", v_t[1] - v_t[0], 35);
      chk("b2b_period_2", v_t[2] - v_t[1], 35);
    end
    chk("b2b_load_pulses", load_cnt, 3);

    repeat (60) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("final_idle_inst%0d", i), int'(busy[i]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
